// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input-path control FSM.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam int WAIT_MAX  = 32;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Selects one per-port flag; addresses outside the port range read as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                    input logic [ADDR_W-1:0]    addr);
    logic sel_s;
    sel_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel_s = vec[i];
      end else begin
        sel_s = sel_s;
      end
    end
    return sel_s;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter bounding the time spent in WAIT_TILL_EMPTY.
module router_wait_timer #(
  parameter int MAX = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_r;

  // Counter clears while idle and saturates at its terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (start) begin
      cnt_r <= {CW{1'b0}};
    end else if (count_en && (cnt_r != CW'(MAX - 1))) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == CW'(MAX - 1));

endmodule

// File: rtl/router_fsm.sv
// Router input-path control FSM. Optional WAIT_TILL_EMPTY timeout is enabled
// by defining ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [7:0]           d_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_pkt
);

  state_t            state_r;
  state_t            next_s;
  logic [ADDR_W-1:0] addr_q_r;
  logic [ADDR_W-1:0] hdr_addr_s;
  logic              hdr_ok_s;
  logic              timeout_s;
  logic              expire_s;
  logic              d_in_unused_s;

  assign hdr_addr_s    = d_in[ADDR_W-1:0];
  assign hdr_ok_s      = (int'(hdr_addr_s) < NUM_PORTS);
  assign d_in_unused_s = ^d_in[7:ADDR_W];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  router_wait_timer #(.MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (state_r != WAIT_TILL_EMPTY),
    .count_en (state_r == WAIT_TILL_EMPTY),
    .expire   (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state logic; a soft reset of the addressed port overrides everything.
  always_comb begin
    next_s    = state_r;
    timeout_s = 1'b0;
    if ((state_r != DECODE_ADDRESS) && port_bit(soft_reset, addr_q_r)) begin
      next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid && hdr_ok_s) begin
            if (port_bit(fifo_empty, hdr_addr_s)) next_s = LOAD_FIRST_DATA;
            else                                  next_s = WAIT_TILL_EMPTY;
          end else begin
            next_s = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: next_s = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_s = FIFO_FULL_STATE;
          else if (!pkt_valid) next_s = LOAD_PARITY;
          else                 next_s = LOAD_DATA;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) next_s = LOAD_AFTER_FULL;
          else            next_s = FIFO_FULL_STATE;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_s = DECODE_ADDRESS;
          else if (low_pkt_valid) next_s = LOAD_PARITY;
          else                    next_s = LOAD_DATA;
        end
        LOAD_PARITY: next_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) next_s = FIFO_FULL_STATE;
          else           next_s = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          // A FIFO draining on the expiry cycle still wins over the abort.
          if (port_bit(fifo_empty, addr_q_r)) begin
            next_s = LOAD_FIRST_DATA;
          end else if (expire_s) begin
            next_s    = DECODE_ADDRESS;
            timeout_s = 1'b1;
          end else begin
            next_s = WAIT_TILL_EMPTY;
          end
        end
        default: next_s = DECODE_ADDRESS;
      endcase
    end
  end

  // State, captured address and state-decoded outputs, all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= DECODE_ADDRESS;
      addr_q_r      <= {ADDR_W{1'b0}};
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
      drop_pkt      <= 1'b0;
    end else begin
      state_r <= next_s;
      if ((state_r == DECODE_ADDRESS) && pkt_valid) begin
        addr_q_r <= hdr_addr_s;
      end else begin
        addr_q_r <= addr_q_r;
      end
      detect_add    <= (next_s == DECODE_ADDRESS);
      lfd_state     <= (next_s == LOAD_FIRST_DATA);
      ld_state      <= (next_s == LOAD_DATA);
      laf_state     <= (next_s == LOAD_AFTER_FULL);
      full_state    <= (next_s == FIFO_FULL_STATE);
      rst_int_reg   <= (next_s == CHECK_PARITY_ERROR);
      write_enb_reg <= (next_s == LOAD_DATA) || (next_s == LOAD_PARITY) ||
                       (next_s == LOAD_AFTER_FULL);
      busy          <= (next_s != DECODE_ADDRESS) && (next_s != LOAD_DATA);
      drop_pkt      <= timeout_s;
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm against a phase-level reference model.
module tb_router_fsm;
  import router_pkg::*;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_LAF = 3, P_FULL = 4,
                 P_LP = 5, P_CPE = 6, P_WAIT = 7;

  logic clk = 1'b0;
  logic rst;
  logic pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [7:0] d_in;
  logic [NUM_PORTS-1:0] fifo_empty, soft_reset;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic rst_int_reg, write_enb_reg, busy, drop_pkt;

  int n_vec = 0;
  int n_err = 0;

  int   m_phase;
  int   m_addr;
  int   m_wait;
  logic m_drop;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .d_in(d_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .drop_pkt(drop_pkt)
  );

  wire [8:0] obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    rst_int_reg, write_enb_reg, busy, drop_pkt};

  function automatic logic [8:0] exp_vec();
    logic we, bz;
    we = (m_phase == P_LD) || (m_phase == P_LP) || (m_phase == P_LAF);
    bz = !((m_phase == P_DEC) || (m_phase == P_LD));
    return {m_phase == P_DEC, m_phase == P_LFD, m_phase == P_LD, m_phase == P_LAF,
            m_phase == P_FULL, m_phase == P_CPE, we, bz, m_drop};
  endfunction

  task automatic model_reset();
    m_phase = P_DEC; m_addr = 0; m_wait = 0; m_drop = 1'b0;
  endtask

  // Advance the reference model by one clock using the current inputs.
  task automatic model_clock();
    int nxt;
    int a;
    logic drop;
    nxt = m_phase; drop = 1'b0; a = int'(d_in[1:0]);
    if (rst) begin
      model_reset();
      return;
    end
    if (m_phase != P_DEC && soft_reset[m_addr]) nxt = P_DEC;
    else begin
      case (m_phase)
        P_DEC:  if (pkt_valid && a < NUM_PORTS) nxt = fifo_empty[a] ? P_LFD : P_WAIT;
        P_LFD:  nxt = P_LD;
        P_LD:   nxt = fifo_full ? P_FULL : (!pkt_valid ? P_LP : P_LD);
        P_FULL: nxt = fifo_full ? P_FULL : P_LAF;
        P_LAF:  nxt = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
        P_LP:   nxt = P_CPE;
        P_CPE:  nxt = fifo_full ? P_FULL : P_DEC;
        P_WAIT: begin
          if (fifo_empty[m_addr]) nxt = P_LFD;
          else if (TIMEOUT_EN && m_wait >= WAIT_MAX - 1) begin nxt = P_DEC; drop = 1'b1; end
          else m_wait++;
        end
        default: nxt = P_DEC;
      endcase
    end
    if (m_phase == P_DEC && pkt_valid) m_addr = a;
    if (nxt == P_WAIT && m_phase != P_WAIT) m_wait = 0;
    m_phase = nxt;
    m_drop  = drop;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_in(input logic pv, input logic [7:0] d, input logic ff,
                        input logic [2:0] fe, input logic [2:0] sr,
                        input logic pd, input logic lpv);
    pkt_valid = pv; d_in = d; fifo_full = ff; fifo_empty = fe;
    soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic test_reset();
    set_in(1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    tick(); tick();
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL reset: got %b want %b", obs, 9'b1_0000_0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_packet();
    set_in(1'b1, 8'h15, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL basic_packet step %0d: got %b want %b", i, obs, exp_vec());
      end
      if (i == 0) begin
        n_vec++;
        if (!(lfd_state === 1'b1 && busy === 1'b1)) begin
          n_err++; $display("FAIL header_lfd: got lfd=%b busy=%b want 1 1", lfd_state, busy);
        end
      end
      if (i == 1) begin
        n_vec++;
        if ({ld_state, write_enb_reg, busy} !== 3'b110) begin
          n_err++; $display("FAIL first_ld: got %b want 110", {ld_state, write_enb_reg, busy});
        end
      end
      d_in = 8'($urandom);
      pkt_valid = (i < 8);
    end
  endtask

  task automatic test_fifo_full();
    set_in(1'b1, 8'h14, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL fifo_full step %0d: got %b want %b", i, obs, exp_vec());
      end
      if (i == 4) begin
        n_vec++;
        if ({full_state, write_enb_reg} !== 2'b10) begin
          n_err++; $display("FAIL full_state: got %b want 10", {full_state, write_enb_reg});
        end
      end
      d_in = 8'($urandom);
      fifo_full = (i >= 3 && i < 6);
      pkt_valid = (i < 9);
    end
  endtask

  task automatic test_wait_empty();
    set_in(1'b1, 8'h02, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL wait_empty step %0d: got %b want %b", i, obs, exp_vec());
      end
      pkt_valid = (i >= 5 && i < 7);
      if (i == 4) fifo_empty = 3'b111;
    end
  endtask

  task automatic test_soft_reset();
    set_in(1'b1, 8'h01, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL soft_reset step %0d: got %b want %b", i, obs, exp_vec());
      end
      if (i == 2) begin
        n_vec++;
        if (ld_state !== 1'b1) begin
          n_err++; $display("FAIL soft_reset_other_port: got ld=%b want 1", ld_state);
        end
      end
      soft_reset = (i == 1) ? 3'b100 : ((i == 2) ? 3'b010 : 3'b000);
      pkt_valid = (i < 2);
    end
  endtask

  task automatic test_invalid_addr();
    set_in(1'b1, {6'h3C, INVALID_ADDR}, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec() || lfd_state !== 1'b0) begin
        n_err++; $display("FAIL invalid_addr step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    pkt_valid = 1'b0;
  endtask

  task automatic test_wait_timeout();
    int drops;
    drops = 0;
    set_in(1'b1, 8'h00, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < WAIT_MAX + 4; i++) begin
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL wait_timeout step %0d: got %b want %b", i, obs, exp_vec());
      end
      if (drop_pkt === 1'b1) drops++;
      pkt_valid = 1'b0;
    end
    n_vec++;
    if (drops !== (TIMEOUT_EN ? 1 : 0)) begin
      n_err++; $display("FAIL drop_count: got %0d want %0d", drops, TIMEOUT_EN ? 1 : 0);
    end
    fifo_empty = 3'b111;
    tick();
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL wait_release: got %b want %b", obs, exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    set_in(1'b1, 8'h01, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL async_reset: got %b want %b", obs, 9'b1_0000_0000);
    end
    pkt_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 8) != 0, 8'($urandom), ($urandom % 6) == 0, 3'($urandom),
             (($urandom % 20) == 0) ? 3'($urandom) : 3'b000,
             ($urandom % 4) == 0, ($urandom % 4) == 0);
      if (($urandom % 250) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_basic_packet();
    test_fifo_full();
    test_wait_empty();
    test_soft_reset();
    test_invalid_addr();
    test_wait_timeout();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
